dflop_bank_write_arbiter: RTL and testbench

- Shares one bank of load-enabled D flip-flop registers (NREGS words × WIDTH bits, each bit a load-gated DFlop cell) between NREQ requesters.
- Grants requesters round-robin and drives the bank's per-word load strobes and shared din bus.
- Reads the written word back one cycle later to confirm the write.
- Acknowledges each requester with a pass/fail flag and keeps a saturating error count.

---
 rtl/dflop_bank_write_arbiter_pkg.sv | 26 ++
 rtl/dflop_bank_write_arbiter_rr_arbiter.sv | 36 +++
 rtl/dflop_bank_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dflop_bank_write_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dflop_bank_write_arbiter_pkg.sv
// Shared definitions for the DFlop bank write arbiter.
//   state_t     : transaction FSM states (IDLE -> LOAD -> CHECK)
//   ERR_CNT_W   : width of the saturating mismatch counter
//   ERR_CNT_MAX : saturation value of that counter
//   onehot()    : 32-bit one-hot of idx, all-zero when idx is out of range n
package dflop_bank_write_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam int unsigned ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

   // Out-of-range indices yield zero so an unmapped address strobes nothing.
   function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
      logic [31:0] v;
      v = '0;
      if ((idx < n) && (idx < 32))
         v = 32'd1 << idx;
      return v;
   endfunction

endpackage

// File: rtl/dflop_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin search: the first set request at or after the
// pointer (wrapping modulo NREQ) wins. The caller registers the result.
// Ports:
//   i_req   [NREQ-1:0] request vector
//   i_ptr   [PW-1:0]   priority pointer (highest-priority index)
//   o_gnt   [PW-1:0]   winning index (0 when nothing requested)
//   o_valid            at least one request present
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [PW-1:0]   o_gnt,
   output logic            o_valid
);

   int unsigned w_idx;

   always_comb begin
      o_gnt   = '0;
      o_valid = 1'b0;
      w_idx   = 0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         w_idx = (32'(i_ptr) + off) % NREQ;
         // Constant-index compare keeps the request select a plain mux.
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!o_valid && (w_idx == i) && i_req[i]) begin
               o_gnt   = i[PW-1:0];
               o_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dflop_bank_write_arbiter.sv
// Shares one bank of load-enabled DFlop words between NREQ requesters.
// Round-robin grant, one-cycle load strobe, one-cycle readback check, then a
// per-requester ack with pass/fail and a saturating mismatch count.
// Ports:
//   clk        clock, rising edge
//   arst       asynchronous reset, active low
//   req        [NREQ]        per-requester level request, held until ack
//   addr       [NREQ*AW]     per-requester target word
//   wdata      [NREQ*WIDTH]  per-requester write data
//   bank_dout  [NREGS*WIDTH] current bank contents
//   load       [NREGS]       one-hot word load strobe
//   din        [WIDTH]       shared bank data bus (holds last value)
//   ack        [NREQ]        one-cycle completion pulse
//   wr_err                   readback mismatch, valid with ack
//   busy                     transaction in flight (LOAD/CHECK)
//   err_cnt    [8]           saturating mismatch count
module dflop_bank_write_arbiter
   import dflop_bank_write_arbiter_pkg::*;
#(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned NREGS = 4,
   localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1,
   localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*AW-1:0]     addr,
   input  logic [NREQ*WIDTH-1:0]  wdata,
   input  logic [NREGS*WIDTH-1:0] bank_dout,
   output logic [NREGS-1:0]       load,
   output logic [WIDTH-1:0]       din,
   output logic [NREQ-1:0]        ack,
   output logic                   wr_err,
   output logic                   busy,
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   state_t                r_state, w_state_nxt;
   logic [PW-1:0]         r_ptr, w_ptr_nxt;
   logic [PW-1:0]         r_g, w_g_nxt;
   logic [AW-1:0]         r_a, w_a_nxt;
   logic [WIDTH-1:0]      r_d, w_d_nxt;
   logic [NREGS-1:0]      r_load, w_load_nxt;
   logic [WIDTH-1:0]      r_din, w_din_nxt;
   logic [NREQ-1:0]       r_ack, w_ack_nxt;
   logic                  r_busy, w_busy_nxt;
   logic [ERR_CNT_W-1:0]  r_err_cnt, w_cnt_nxt;

   logic [PW-1:0]         w_gnt;
   logic                  w_valid;
   logic [AW-1:0]         w_sel_addr;
   logic [WIDTH-1:0]      w_sel_data;
   logic [WIDTH-1:0]      w_rd_word;
   logic                  w_rd_hit;
   logic                  w_mismatch;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   // Winner's address/data slice.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (32'(w_gnt) == i) begin
            w_sel_addr = addr[i*AW +: AW];
            w_sel_data = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   // Readback of the latched word; an address with no backing word never hits
   // and therefore always reports a mismatch.
   always_comb begin
      w_rd_word = '0;
      w_rd_hit  = 1'b0;
      for (int unsigned k = 0; k < NREGS; k++) begin
         if (32'(r_a) == k) begin
            w_rd_word = bank_dout[k*WIDTH +: WIDTH];
            w_rd_hit  = 1'b1;
         end
      end
   end

   assign w_mismatch = !w_rd_hit || (w_rd_word != r_d);

   // Next-state and next-output logic; outputs are registered on the
   // transition into the state in which they must be visible.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_g_nxt     = r_g;
      w_a_nxt     = r_a;
      w_d_nxt     = r_d;
      w_load_nxt  = '0;
      w_din_nxt   = r_din;
      w_ack_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = r_err_cnt;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_g_nxt     = w_gnt;
               w_a_nxt     = w_sel_addr;
               w_d_nxt     = w_sel_data;
               w_load_nxt  = NREGS'(onehot(32'(w_sel_addr), NREGS));
               w_din_nxt   = w_sel_data;
               w_busy_nxt  = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_ack_nxt   = NREQ'(onehot(32'(r_g), NREQ));
            w_busy_nxt  = 1'b1;
            w_state_nxt = CHECK;
         end
         CHECK: begin
            w_ptr_nxt = (32'(r_g) == NREQ - 1) ? '0 : r_g + 1'b1;
            if (w_mismatch && (r_err_cnt != ERR_CNT_MAX))
               w_cnt_nxt = r_err_cnt + 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_g       <= '0;
         r_a       <= '0;
         r_d       <= '0;
         r_load    <= '0;
         r_din     <= '0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_g       <= w_g_nxt;
         r_a       <= w_a_nxt;
         r_d       <= w_d_nxt;
         r_load    <= w_load_nxt;
         r_din     <= w_din_nxt;
         r_ack     <= w_ack_nxt;
         r_busy    <= w_busy_nxt;
         r_err_cnt <= w_cnt_nxt;
      end
   end

   assign load    = r_load;
   assign din     = r_din;
   assign ack     = r_ack;
   assign busy    = r_busy;
   assign err_cnt = r_err_cnt;
   assign wr_err  = (r_state == CHECK) && w_mismatch;

endmodule

// File: tb/tb_dflop_bank_write_arbiter.sv
// Directed bench for dflop_bank_write_arbiter with a behavioural DFlop bank.
module tb_dflop_bank_write_arbiter;

   logic        clk;
   logic        arst;
   logic [3:0]  req;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] bank_dout;
   logic [3:0]  load;
   logic [7:0]  din;
   logic [3:0]  ack;
   logic        wr_err;
   logic        busy;
   logic [7:0]  err_cnt;

   logic [7:0]  bank_q [4];
   logic        force_w1;

   int n_chk;
   int n_pass;
   int n_fail;
   int exp_cnt;

   dflop_bank_write_arbiter #(.NREQ(4), .WIDTH(8), .NREGS(4)) dut (
      .clk       (clk),
      .arst      (arst),
      .req       (req),
      .addr      (addr),
      .wdata     (wdata),
      .bank_dout (bank_dout),
      .load      (load),
      .din       (din),
      .ack       (ack),
      .wr_err    (wr_err),
      .busy      (busy),
      .err_cnt   (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bank of load-gated DFlop words.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         for (int k = 0; k < 4; k++) bank_q[k] <= 8'h00;
      end else begin
         for (int k = 0; k < 4; k++)
            if (load[k]) bank_q[k] <= din;
      end
   end

   // Word 1 can be overridden to model a stuck readback.
   always_comb begin
      bank_dout = '0;
      for (int k = 0; k < 4; k++)
         bank_dout[k*8 +: 8] = (force_w1 && (k == 1)) ? 8'h00 : bank_q[k];
   end

   initial begin
      #100_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction from the IDLE cycle's sampling edge onward: LOAD, CHECK,
   // then the following IDLE cycle. Requests are updated at the LOAD and
   // CHECK sample points as the requesters would.
   task automatic do_txn(input int g, input int a, input logic [7:0] d, input logic err,
                         input logic [3:0] req_load, input logic [3:0] req_chk);
      @(negedge clk);
      check("load",   {28'd0, load}, 32'd1 << a);
      check("din",    {24'd0, din}, {24'd0, d});
      check("busy_l", {31'd0, busy}, 32'd1);
      check("ack_l",  {28'd0, ack}, 32'd0);
      req = req_load;
      @(negedge clk);
      check("ack",    {28'd0, ack}, 32'd1 << g);
      check("wr_err", {31'd0, wr_err}, {31'd0, err});
      check("busy_c", {31'd0, busy}, 32'd1);
      check("load_c", {28'd0, load}, 32'd0);
      if (err && (exp_cnt != 255)) exp_cnt++;
      req = req_chk;
      @(negedge clk);
      check("ack_i",  {28'd0, ack}, 32'd0);
      check("busy_i", {31'd0, busy}, 32'd0);
      check("cnt",    {24'd0, err_cnt}, exp_cnt);
      check("bank",   {24'd0, bank_q[a]}, {24'd0, d});
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0; exp_cnt = 0;
      arst = 1'b0; req = '0; addr = '0; wdata = '0; force_w1 = 1'b0;
      #103;
      check("rst_load", {28'd0, load}, 32'd0);
      check("rst_din",  {24'd0, din}, 32'd0);
      check("rst_ack",  {28'd0, ack}, 32'd0);
      check("rst_err",  {31'd0, wr_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt",  {24'd0, err_cnt}, 32'd0);
      @(negedge clk);
      arst = 1'b1;

      // Single write: requester 0, word 2, A5.
      addr[1:0] = 2'd2; wdata[7:0] = 8'hA5; req = 4'b0001;
      do_txn(0, 2, 8'hA5, 1'b0, 4'b0001, 4'b0000);
      check("din_hold", {24'd0, din}, 32'hA5);

      // Reset pulse to bring the pointer back to 0.
      arst = 1'b0; #1;
      check("rst2_din", {24'd0, din}, 32'd0);
      check("rst2_ptr_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      arst = 1'b1;

      // Contention: all four request, each drops on its own ack.
      addr  = {2'd3, 2'd2, 2'd1, 2'd0};
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      req   = 4'b1111;
      do_txn(0, 0, 8'h10, 1'b0, 4'b1111, 4'b1110);
      do_txn(1, 1, 8'h11, 1'b0, 4'b1110, 4'b1100);
      do_txn(2, 2, 8'h12, 1'b0, 4'b1100, 4'b1000);
      do_txn(3, 3, 8'h13, 1'b0, 4'b1000, 4'b0000);

      // Fairness: 0 and 3 held; grants alternate.
      addr  = {2'd3, 2'd0, 2'd0, 2'd0};
      wdata = {8'h33, 8'h00, 8'h00, 8'h11};
      req   = 4'b1001;
      do_txn(0, 0, 8'h11, 1'b0, 4'b1001, 4'b1001);
      do_txn(3, 3, 8'h33, 1'b0, 4'b1001, 4'b1001);
      do_txn(0, 0, 8'h11, 1'b0, 4'b1001, 4'b1001);
      do_txn(3, 3, 8'h33, 1'b0, 4'b1001, 4'b0000);

      // Readback fault: word 1 reads as 00 while requester 2 writes FF.
      force_w1 = 1'b1;
      addr  = {2'd0, 2'd1, 2'd0, 2'd0};
      wdata = {8'h00, 8'hFF, 8'h00, 8'h00};
      req   = 4'b0100;
      for (int i = 0; i < 300; i++)
         do_txn(2, 1, 8'hFF, 1'b1, 4'b0100, (i == 299) ? 4'b0000 : 4'b0100);
      check("cnt_sat", {24'd0, err_cnt}, 32'd255);
      force_w1 = 1'b0;

      // Reset during LOAD. Pointer is 3, so requester 3 is in LOAD.
      addr  = {2'd0, 2'd0, 2'd0, 2'd3};
      wdata = {8'h77, 8'h00, 8'h00, 8'h3C};
      req   = 4'b1001;
      @(negedge clk);
      check("mid_load", {28'd0, load}, 32'b0001);
      arst = 1'b0; #1;
      check("mid_load0", {28'd0, load}, 32'd0);
      check("mid_busy0", {31'd0, busy}, 32'd0);
      check("mid_ack0",  {28'd0, ack}, 32'd0);
      check("mid_cnt0",  {24'd0, err_cnt}, 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      check("mid_noack", {28'd0, ack}, 32'd0);
      check("mid_idle",  {31'd0, busy}, 32'd0);
      arst = 1'b1;
      do_txn(0, 3, 8'h3C, 1'b0, 4'b1001, 4'b1000);
      do_txn(3, 0, 8'h77, 1'b0, 4'b1000, 4'b0000);

      // Early drop: request gone after grant, transaction still completes.
      addr[1:0] = 2'd1; wdata[7:0] = 8'h5A; req = 4'b0001;
      do_txn(0, 1, 8'h5A, 1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("drop_load", {28'd0, load}, 32'd0);
         check("drop_busy", {31'd0, busy}, 32'd0);
         check("drop_ack",  {28'd0, ack}, 32'd0);
      end
      check("drop_din", {24'd0, din}, 32'h5A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
